// File: rtl/chess_pkg.sv
// chess_pkg -- shared definitions for the chess clock.
//   state_t      : controller state encoding
//   DIGIT_MAX9/5 : BCD digit values written on a borrow (units / tens of seconds)
//   bcd_time_t   : 20-bit display field {m10, m1, s10, s1, t} = MM:SS.t
//   init_time()  : builds MM:00.0 from a minute count
package chess_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_A,
    ST_RUN_B,
    ST_PAUSE,
    ST_TIMEOUT_A,
    ST_TIMEOUT_B
  } state_t;

  localparam logic [3:0] DIGIT_MAX9 = 4'd9;
  localparam logic [3:0] DIGIT_MAX5 = 4'd5;

  localparam int TIME_W = 20;

  typedef struct packed {
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
    logic [3:0] t;
  } bcd_time_t;

  function automatic bcd_time_t init_time(input int minutes);
    bcd_time_t v;
    v     = '0;
    v.m10 = 4'(minutes / 10);
    v.m1  = 4'(minutes % 10);
    return v;
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// bcd_down_counter -- one player's MM:SS.t clock, counting down in tenths.
// Ports:
//   clk   : system clock
//   rst   : synchronous active-high reset, reloads INIT_MIN:00.0
//   load  : reload INIT_MIN:00.0 (wins over dec)
//   dec   : subtract one tenth; held at 00:00.0 once there
//   value : BCD {m10, m1, s10, s1, t}
//   zero  : value is 00:00.0
module bcd_down_counter
  import chess_pkg::*;
#(
  parameter int INIT_MIN = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              dec,
  output logic [TIME_W-1:0] value,
  output logic              zero
);

  localparam bcd_time_t RELOAD = init_time(INIT_MIN);

  bcd_time_t cur;
  bcd_time_t nxt;

  assign value = cur;
  assign zero  = (cur == '0);

  // Borrow ripples from tenths upward; m10 only ever borrows from m1,
  // and the zero guard keeps it from wrapping.
  always_comb begin
    nxt = cur;
    if (dec && !zero) begin
      if (cur.t != 4'd0) begin
        nxt.t = cur.t - 4'd1;
      end else begin
        nxt.t = DIGIT_MAX9;
        if (cur.s1 != 4'd0) begin
          nxt.s1 = cur.s1 - 4'd1;
        end else begin
          nxt.s1 = DIGIT_MAX9;
          if (cur.s10 != 4'd0) begin
            nxt.s10 = cur.s10 - 4'd1;
          end else begin
            nxt.s10 = DIGIT_MAX5;
            if (cur.m1 != 4'd0) begin
              nxt.m1 = cur.m1 - 4'd1;
            end else begin
              nxt.m1  = DIGIT_MAX9;
              nxt.m10 = cur.m10 - 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cur <= RELOAD;
    end else begin
      cur <= nxt;
    end
  end

endmodule

// File: rtl/chess_timer.sv
// chess_timer -- two-player chess clock controller.
// Ports:
//   clk_50m              : system clock, the only clock
//   rst                  : synchronous active-high reset
//   clk_10               : 10 Hz square wave, rising edge = one tenth elapsed
//   clk_763              : buzzer tone square wave
//   btn_start/pause/a/b  : single-cycle debounced button pulses
//   time_a, time_b       : BCD MM:SS.t per player
//   turn                 : active player (0 = A, 1 = B)
//   running              : clock running for either player
//   timeout_a/b          : flag fallen
//   buzzer               : gated tone output
//
// state        | meaning
// -------------+----------------------------------------------
// ST_IDLE      | both clocks loaded, waiting for btn_start
// ST_RUN_A     | A's clock counting down
// ST_RUN_B     | B's clock counting down
// ST_PAUSE     | frozen; pause_turn remembers whose clock resumes
// ST_TIMEOUT_A | A's flag fell, times frozen until btn_start
// ST_TIMEOUT_B | B's flag fell, times frozen until btn_start
module chess_timer
  import chess_pkg::*;
#(
  parameter int INIT_MIN   = 5,
  parameter int BUZZ_TICKS = 20
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              clk_10,
  input  logic              clk_763,
  input  logic              btn_start,
  input  logic              btn_pause,
  input  logic              btn_a,
  input  logic              btn_b,
  output logic [TIME_W-1:0] time_a,
  output logic [TIME_W-1:0] time_b,
  output logic              turn,
  output logic              running,
  output logic              timeout_a,
  output logic              timeout_b,
  output logic              buzzer
);

  localparam int                BW         = $clog2(BUZZ_TICKS + 1);
  localparam logic [BW-1:0]     BUZZ_LOAD  = BW'(BUZZ_TICKS);
  localparam logic [BW-1:0]     BUZZ_ONE   = BW'(1);
  localparam logic [TIME_W-1:0] LAST_TENTH = 20'h00001;

  state_t        state, state_nxt;
  logic          pause_turn, pause_turn_nxt;
  logic          clk_10_q;
  logic          tick;
  logic          dec_a, dec_b;
  logic          load_times;
  logic          buzz_long, buzz_short;
  logic          zero_a, zero_b;
  logic [BW-1:0] buzz_cnt;
  logic          buzz_en;

  assign tick    = clk_10 & ~clk_10_q;
  assign buzz_en = (buzz_cnt != '0);

  bcd_down_counter #(.INIT_MIN(INIT_MIN)) u_cnt_a (
    .clk   (clk_50m),
    .rst   (rst),
    .load  (load_times),
    .dec   (dec_a),
    .value (time_a),
    .zero  (zero_a)
  );

  bcd_down_counter #(.INIT_MIN(INIT_MIN)) u_cnt_b (
    .clk   (clk_50m),
    .rst   (rst),
    .load  (load_times),
    .dec   (dec_b),
    .value (time_b),
    .zero  (zero_b)
  );

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state      <= ST_IDLE;
      pause_turn <= 1'b0;
      clk_10_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pause_turn <= pause_turn_nxt;
      clk_10_q   <= clk_10;
    end
  end

  // Pause outranks everything in a running state, including a coinciding
  // tick: the clock freezes from this edge on. A tick reaching 00:00.0
  // swallows a same-cycle turn button.
  always_comb begin
    state_nxt      = state;
    pause_turn_nxt = pause_turn;
    dec_a          = 1'b0;
    dec_b          = 1'b0;
    load_times     = 1'b0;
    buzz_long      = 1'b0;
    buzz_short     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (btn_start) state_nxt = ST_RUN_A;
      end
      ST_RUN_A: begin
        if (btn_pause) begin
          state_nxt      = ST_PAUSE;
          pause_turn_nxt = 1'b0;
        end else if (tick && (time_a == LAST_TENTH || zero_a)) begin
          dec_a     = 1'b1;
          state_nxt = ST_TIMEOUT_A;
          buzz_long = 1'b1;
        end else begin
          dec_a = tick;
          if (btn_a) begin
            state_nxt  = ST_RUN_B;
            buzz_short = 1'b1;
          end
        end
      end
      ST_RUN_B: begin
        if (btn_pause) begin
          state_nxt      = ST_PAUSE;
          pause_turn_nxt = 1'b1;
        end else if (tick && (time_b == LAST_TENTH || zero_b)) begin
          dec_b     = 1'b1;
          state_nxt = ST_TIMEOUT_B;
          buzz_long = 1'b1;
        end else begin
          dec_b = tick;
          if (btn_b) begin
            state_nxt  = ST_RUN_A;
            buzz_short = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (btn_pause) state_nxt = pause_turn ? ST_RUN_B : ST_RUN_A;
      end
      ST_TIMEOUT_A, ST_TIMEOUT_B: begin
        if (btn_start) begin
          load_times = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign running   = (state == ST_RUN_A) || (state == ST_RUN_B);
  assign timeout_a = (state == ST_TIMEOUT_A);
  assign timeout_b = (state == ST_TIMEOUT_B);

  always_comb begin
    turn = 1'b0;
    case (state)
      ST_RUN_B, ST_TIMEOUT_B: turn = 1'b1;
      ST_PAUSE:               turn = pause_turn;
      default:                turn = 1'b0;
    endcase
  end

  // A fresh request reloads the count even if a buzz is in progress.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      buzz_cnt <= '0;
      buzzer   <= 1'b0;
    end else begin
      if (buzz_long) begin
        buzz_cnt <= BUZZ_LOAD;
      end else if (buzz_short) begin
        buzz_cnt <= BUZZ_ONE;
      end else if (tick && buzz_en) begin
        buzz_cnt <= buzz_cnt - BUZZ_ONE;
      end
      buzzer <= buzz_en & clk_763;
    end
  end

endmodule
